// File: rtl/kmeans_pixel_streamer_if.sv
// rtl/kmeans_pixel_streamer_if.sv - image load, run control and pixel stream signals of kmeans_pixel_streamer
interface kmeans_pixel_streamer_if #(
    parameter int ADDR_W = 13,
    parameter int ITER_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              means_ready;
    logic              allStable;
    logic [23:0]       Sin;
    logic              valid;
    logic              endOfImage;
    logic              frame_start;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        output wr_en, wr_addr, wr_data, start, means_ready, allStable,
        input  Sin, valid, endOfImage, frame_start, busy, done, timeout, iter_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, means_ready, allStable,
        output Sin, valid, endOfImage, frame_start, busy, done, timeout, iter_count
    );
endinterface

// File: rtl/kmeans_pixel_streamer.sv
// rtl/kmeans_pixel_streamer.sv - replays a stored image once per K-means iteration until means settle or the cap hits
module kmeans_pixel_streamer #(
    parameter int DEPTH    = 2800,
    parameter int ADDR_W   = 13,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    kmeans_pixel_streamer_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, EOI, DONE} state_t;

    logic [23:0]       mem [0:DEPTH-1];
    state_t            state;
    logic [IDX_W-1:0]  rd_addr;
    logic              drain;
    logic              idle_like;
    logic [23:0]       sin_q;
    logic              valid_q;
    logic              eoi_q;
    logic              frame_start_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic [ITER_W-1:0] iter_q;

    assign idle_like = (state == IDLE) || (state == DONE);

    // Image RAM is not reset; it survives aborted runs so a new start replays it.
    always_ff @(posedge clk) begin
        if (idle_like && bus.wr_en && (bus.wr_addr < ADDR_W'(DEPTH)))
            mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_addr       <= '0;
            drain         <= 1'b0;
            sin_q         <= '0;
            valid_q       <= 1'b0;
            eoi_q         <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            iter_q        <= '0;
        end else begin
            frame_start_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        iter_q        <= '0;
                        done_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        rd_addr       <= '0;
                        drain         <= 1'b0;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    // drain is the one extra cycle that lets the last read pixel leave before EOI
                    if (!drain) begin
                        sin_q   <= mem[rd_addr];
                        valid_q <= 1'b1;
                        if (rd_addr == IDX_W'(DEPTH - 1))
                            drain <= 1'b1;
                        else
                            rd_addr <= rd_addr + IDX_W'(1);
                    end else begin
                        sin_q   <= '0;
                        valid_q <= 1'b0;
                        eoi_q   <= 1'b1;
                        drain   <= 1'b0;
                        state   <= EOI;
                    end
                end
                EOI: begin
                    if (bus.means_ready) begin
                        eoi_q <= 1'b0;
                        if (bus.allStable || (iter_q == ITER_W'(MAX_ITER - 1))) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            timeout_q <= !bus.allStable;
                        end else begin
                            iter_q        <= iter_q + ITER_W'(1);
                            frame_start_q <= 1'b1;
                            rd_addr       <= '0;
                            state         <= STREAM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Sin         = sin_q;
    assign bus.valid       = valid_q;
    assign bus.endOfImage  = eoi_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.iter_count  = iter_q;
endmodule

// File: tb/tb_kmeans_pixel_streamer.sv
// tb/tb_kmeans_pixel_streamer.sv - scoreboard bench for kmeans_pixel_streamer
module tb_kmeans_pixel_streamer;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 3;
    localparam int MAX_ITER = 3;
    localparam int ITER_W   = 2;

    typedef struct {
        logic [23:0] pix;
        int          iter;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] model_mem [DEPTH];
    int          model_iter;
    bit          model_done;
    exp_t        sb [$];

    kmeans_pixel_streamer_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();

    kmeans_pixel_streamer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every emitted pixel must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid_eoi_exclusive", {31'd0, bus.valid & bus.endOfImage}, 0);
            chk("frame_start_valid_exclusive", {31'd0, bus.frame_start & bus.valid}, 0);
            if (!bus.valid) begin
                chk("sin_zero_when_idle", {8'd0, bus.Sin}, 0);
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got %0h expected none at %0t", bus.Sin, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pixel_data", {8'd0, bus.Sin}, {8'd0, e.pix});
                chk("pixel_iter", {30'd0, bus.iter_count}, e.iter);
            end
        end
    end

    task automatic push_pass(input int it);
        for (int i = 0; i < DEPTH; i++) sb.push_back('{pix: model_mem[i], iter: it});
    endtask

    task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        if (int'(a) < DEPTH) model_mem[int'(a)] = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Called at a negedge while idle/done; returns at the negedge of the frame_start cycle.
    task automatic do_start(input bit with_write, input logic [ADDR_W-1:0] a, input logic [23:0] d);
        bus.start = 1'b1;
        if (with_write) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = a;
            bus.wr_data = d;
            if (int'(a) < DEPTH) model_mem[int'(a)] = d;
        end
        model_iter = 0;
        model_done = 1'b0;
        push_pass(0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("start_frame_start", {31'd0, bus.frame_start}, 1);
        chk("start_busy", {31'd0, bus.busy}, 1);
        chk("start_done_clear", {31'd0, bus.done}, 0);
        chk("start_timeout_clear", {31'd0, bus.timeout}, 0);
        chk("start_iter_zero", {30'd0, bus.iter_count}, 0);
    endtask

    // From the frame_start negedge, expects endOfImage exactly DEPTH+1 cycles later.
    task automatic wait_eoi(input bit disturb);
        int k;
        for (k = 1; k <= DEPTH + 10; k++) begin
            @(negedge clk);
            if (bus.endOfImage) break;
            if (disturb && k == 1) begin
                bus.means_ready = 1'b1;
                bus.allStable   = 1'b1;
                bus.start       = 1'b1;
                bus.wr_en       = 1'b1;
                bus.wr_addr     = 3'd1;
                bus.wr_data     = 24'hFFFFFF;
            end
            if (disturb && k == 2) begin
                bus.means_ready = 1'b0;
                bus.start       = 1'b0;
                bus.wr_en       = 1'b0;
            end
        end
        chk("eoi_latency", k, DEPTH + 1);
        chk("pass_pixels_drained", sb.size(), 0);
    endtask

    task automatic send_means(input bit stable);
        bit cont;
        int d;
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk);
            chk("eoi_held", {31'd0, bus.endOfImage}, 1);
        end
        bus.means_ready = 1'b1;
        bus.allStable   = stable;
        cont = !stable && (model_iter < MAX_ITER - 1);
        if (cont) begin
            model_iter++;
            push_pass(model_iter);
        end else begin
            model_done = 1'b1;
        end
        @(negedge clk);
        bus.means_ready = 1'b0;
        bus.allStable   = 1'($urandom_range(0, 1));
        chk("means_eoi_drop", {31'd0, bus.endOfImage}, 0);
        chk("means_iter", {30'd0, bus.iter_count}, model_iter);
        if (cont) begin
            chk("next_frame_start", {31'd0, bus.frame_start}, 1);
            chk("next_busy", {31'd0, bus.busy}, 1);
        end else begin
            chk("end_done", {31'd0, bus.done}, 1);
            chk("end_busy", {31'd0, bus.busy}, 0);
            chk("end_timeout", {31'd0, bus.timeout}, {31'd0, !stable});
            repeat (3) begin
                @(negedge clk);
                chk("no_extra_frame_start", {31'd0, bus.frame_start}, 0);
                chk("done_held", {31'd0, bus.done}, 1);
            end
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {bus.Sin, bus.valid, bus.endOfImage, bus.frame_start, bus.busy,
                bus.done, bus.timeout, bus.iter_count};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.start       = 1'b0;
        bus.means_ready = 1'b0;
        bus.allStable   = 1'b0;
        model_iter      = 0;
        model_done      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        reset = 1'b0;

        // Load, plus an out-of-range write that would alias onto address 1 if not dropped.
        write_px(3'd0, 24'h112233);
        write_px(3'd1, 24'h445566);
        write_px(3'd2, 24'h778899);
        write_px(3'd3, 24'hAABBCC);
        write_px(3'd5, 24'hDEAD00);

        // Pass 0 with mid-stream noise, pass 1 identical, then converge.
        do_start(1'b0, '0, '0);
        wait_eoi(1'b1);
        send_means(1'b0);
        wait_eoi(1'b0);
        send_means(1'b1);

        // Restart from DONE and run into the iteration cap.
        do_start(1'b0, '0, '0);
        for (int p = 0; p < MAX_ITER; p++) begin
            wait_eoi(1'b0);
            send_means(1'b0);
        end

        // Start together with a write, then reset at the second pixel.
        do_start(1'b1, 3'd0, 24'h0A0B0C);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_outputs", out_vec(), 0);
        #2;
        reset = 1'b0;
        @(negedge clk);
        do_start(1'b0, '0, '0);
        wait_eoi(1'b0);
        send_means(1'b1);

        // Random images and random convergence decisions.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) write_px(ADDR_W'(i), 24'($urandom));
            do_start(1'b0, '0, '0);
            for (int p = 0; p < MAX_ITER && !model_done; p++) begin
                wait_eoi(r[0]);
                send_means($urandom_range(0, 3) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kmeans_pixel_streamer.md
# kmeans_pixel_streamer

Pixel source for the K-means clustering datapath. It holds one image in an internal synchronous RAM and replays it as a `Sin`/`valid`/`endOfImage` stream into `bengine`, one full pass per K-means iteration. After each pass it waits for the updated means. It stops when `mean_file` reports `allStable` or when an iteration cap is reached.

## Interface

Parameters:
- `DEPTH`, 2800: pixels per image (50×56).
- `ADDR_W`, 13: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `MAX_ITER`, 32: maximum passes before forced stop.
- `ITER_W`, 6: width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `wr_en` input 1: image RAM write strobe. Honoured only in IDLE or DONE.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input 24: pixel {R,G,B}, 8 bits each.
- `start` input 1: begin clustering run. Honoured only in IDLE or DONE.
- `means_ready` input 1: one-cycle pulse meaning the means for the current pass are updated (`rgb_ready` path).
- `allStable` input 1: from `mean_file`. Sampled only in the cycle `means_ready` is high.
- `Sin` output 24: pixel data; 0 whenever `valid`=0.
- `valid` output 1: `Sin` carries a pixel this cycle.
- `endOfImage` output 1: pass complete. Level; held until `means_ready`.
- `frame_start` output 1: one-cycle pulse one cycle before the first pixel of every pass. Downstream uses it to clear accumulators.
- `busy` output 1: high outside IDLE and DONE.
- `done` output 1: level; run finished.
- `timeout` output 1: level; run ended at `MAX_ITER` without `allStable`.
- `iter_count` output ITER_W: number of the pass currently executing, 0-based.

## Operation

- Every output resets to 0. Reset puts the FSM in IDLE. RAM contents are not cleared.
- The RAM is DEPTH×24, with a single write port and a 1-cycle-latency read port. Writes to addresses ≥ DEPTH are dropped.
- FSM states are IDLE, STREAM, EOI, DONE.
- **IDLE/DONE**
  - `wr_en` writes the RAM.
  - `start` does the following:
    - clears `iter_count`, `done` and `timeout`
    - asserts `frame_start`
    - sets `rd_addr` to 0
    - moves to STREAM
  - When `start` and `wr_en` are high in the same cycle, the write completes and then the run starts.
- **STREAM**
  - `rd_addr` increments each cycle from 0 to DEPTH-1.
  - A registered `valid` and `Sin` follow the address by one cycle.
  - The cycle after `Sin`=mem[DEPTH-1] is emitted, the FSM moves to EOI.
  - There is no back-pressure; the stream is gapless.
- **EOI**
  - `endOfImage`=1, `valid`=0, `Sin`=0.
  - The FSM stays here until `means_ready`=1, then:
    - If `allStable`=1: go to DONE, set `done`=1, drop `endOfImage`.
    - Else if `iter_count`=MAX_ITER-1: go to DONE, set `done`=1 and `timeout`=1, drop `endOfImage`.
    - Else: increment `iter_count`, drop `endOfImage`, pulse `frame_start`, set `rd_addr` to 0, go to STREAM.
- Inputs ignored by state:
  - `means_ready` outside EOI.
  - `start` and `wr_en` in STREAM and EOI.
- Reset during a run aborts the run immediately. The RAM retains the image, so a new `start` replays the same image.

## Timing

- If `start` is sampled at cycle t:
  - `frame_start`=1 and `busy`=1 at t+1.
  - `valid`=1 with `Sin`=mem[0] at t+2.
  - `Sin`=mem[DEPTH-1] at t+1+DEPTH.
  - `endOfImage`=1 at t+2+DEPTH.
- If `means_ready` is sampled at cycle m while in EOI:
  - At m+1, `endOfImage`=0, and either `done`=1 with `busy`=0, or `frame_start`=1.
  - When the run continues, the first pixel appears at m+2.
- `valid` and `endOfImage` are never high in the same cycle. `frame_start` is never high in the same cycle as `valid`.
- Each pass has exactly DEPTH `valid` cycles.
- `iter_count` changes only in the cycle `frame_start` is high.

## Test plan

- Load: DEPTH=4, write 0x112233, 0x445566, 0x778899, 0xAABBCC, then `start` → `valid` for 4 cycles starting at t+2 with those values in order. `endOfImage` rises at t+6. `frame_start` is high only at t+1.
- Convergence: after pass 0, pulse `means_ready` with `allStable`=0 → second pass with identical data and `iter_count`=1. After it, pulse `means_ready` with `allStable`=1 → `done`=1, `timeout`=0, `busy`=0, no third `frame_start`.
- Cap: MAX_ITER=3, `allStable` held at 0 → exactly 3 passes, then `done`=1 and `timeout`=1 with `iter_count`=2.
- Ignored inputs:
  - `means_ready` pulsed mid-STREAM → no effect on the stream.
  - `wr_en` writing address 1 with 0xFFFFFF mid-stream → next pass still emits 0x445566.
  - `start` mid-stream → no restart.
- Reset mid-pass, at the second pixel → next cycle all outputs are 0 and the FSM is in IDLE. A new `start` replays the full image from mem[0] with `iter_count`=0.
- Restart from DONE: `start` while `done`=1 → `done` and `timeout` clear at t+1, and a fresh pass begins.
